// File: rtl/bsg_axis_txn_engine_if.sv
// AXI-Stream bundle shared by the transaction engine's TX and RX ports.
//   tdata  : beat payload
//   tvalid : source has a beat
//   tkeep  : byte qualifiers
//   tlast  : final beat of a frame
//   tready : sink accepts the beat
// The master modport drives the payload and samples tready.
// The slave modport samples the payload and drives tready.
interface bsg_axis_txn_engine_if #(
  parameter int data_width_p = 32
);
  logic [data_width_p-1:0]   tdata;
  logic                      tvalid;
  logic [data_width_p/8-1:0] tkeep;
  logic                      tlast;
  logic                      tready;

  modport master (output tdata, output tvalid, output tkeep, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tkeep, input  tlast, output tready);
endinterface

// File: rtl/bsg_axis_txn_engine.sv
// Programmable-length AXI-Stream transaction engine.
// TX: drains the PS-to-PL FIFO onto m_axis. It frames exactly len beats and
//     applies last_keep to the final beat.
// RX: forwards s_axis into the PL-to-PS FIFO. It classifies the received
//     frame length as ok, short or long, and drains overlong frames up to tlast.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i                 abort, clear status, sample len_i/last_keep_i, arm both sides
//   len_i, last_keep_i      transaction length in beats, keep for the final TX beat
//   tx_data_i/tx_v_i/tx_yumi_o   PS-to-PL FIFO head and dequeue
//   m_axis (master)         outgoing AXIS
//   s_axis (slave)          incoming AXIS (tkeep ignored)
//   rx_data_o/rx_v_o/rx_ready_i  PL-to-PS FIFO enqueue side
//   tx_count_o, rx_count_o  beats moved this transaction (rx saturates at max_len_p)
//   status_o                {0, rx_busy, tx_busy, cfg_err, rx_long, rx_short, rx_ok, tx_done}
module bsg_axis_txn_engine #(
  parameter  int data_width_p  = 32,
  parameter  int max_len_p     = 256,
  localparam int lg_len_lp     = $clog2(max_len_p + 1),
  localparam int keep_width_lp = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [lg_len_lp-1:0]     len_i,
  input  logic [keep_width_lp-1:0] last_keep_i,
  input  logic [data_width_p-1:0]  tx_data_i,
  input  logic                     tx_v_i,
  output logic                     tx_yumi_o,
  bsg_axis_txn_engine_if.master    m_axis,
  bsg_axis_txn_engine_if.slave     s_axis,
  output logic [data_width_p-1:0]  rx_data_o,
  output logic                     rx_v_o,
  input  logic                     rx_ready_i,
  output logic [lg_len_lp-1:0]     tx_count_o,
  output logic [lg_len_lp-1:0]     rx_count_o,
  output logic [7:0]               status_o
);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DRAIN, RX_DONE} rx_state_e;

  localparam int st_tx_done_lp  = 0;
  localparam int st_rx_ok_lp    = 1;
  localparam int st_rx_short_lp = 2;
  localparam int st_rx_long_lp  = 3;
  localparam int st_cfg_err_lp  = 4;

  localparam logic [lg_len_lp-1:0] one_lp     = lg_len_lp'(1);
  localparam logic [lg_len_lp-1:0] max_len_lp = lg_len_lp'(max_len_p);

  tx_state_e tx_state_reg, tx_state_next;
  rx_state_e rx_state_reg, rx_state_next;

  logic [lg_len_lp-1:0]     len_reg, len_next;
  logic [keep_width_lp-1:0] last_keep_reg, last_keep_next;
  logic [lg_len_lp-1:0]     tx_count_reg, tx_count_next;
  logic [lg_len_lp-1:0]     rx_count_reg, rx_count_next;
  logic [4:0]               status_reg, status_next;

  logic                     len_ok;
  logic [lg_len_lp-1:0]     len_m1;
  logic                     tx_send, tx_last, tx_fire;
  logic                     rx_open, rx_fire, rx_len_hit;
  logic [keep_width_lp-1:0] keep_mux;
  logic                     unused_keep;

  assign len_ok     = (len_i != '0) && (len_i <= max_len_lp);
  assign len_m1     = len_reg - one_lp;
  assign tx_send    = (tx_state_reg == TX_SEND);
  assign tx_last    = (tx_count_reg == len_m1);
  assign tx_fire    = tx_send & tx_v_i & m_axis.tready;
  assign rx_open    = (rx_state_reg == RX_RECV) || (rx_state_reg == RX_DRAIN);
  assign rx_fire    = rx_open & s_axis.tvalid & rx_ready_i;
  assign rx_len_hit = (rx_count_reg == len_m1);

  // Incoming byte qualifiers carry no meaning for the PL-to-PS FIFO.
  assign unused_keep = ^s_axis.tkeep;

  // Final TX beat takes the programmed keep; every other beat is full width.
  for (genvar gi = 0; gi < keep_width_lp; gi++) begin : g_keep
    assign keep_mux[gi] = tx_last ? last_keep_reg[gi] : 1'b1;
  end

  // TX datapath is a straight combinational pass from FIFO head to the bus.
  assign m_axis.tdata  = tx_send ? tx_data_i : '0;
  assign m_axis.tvalid = tx_send & tx_v_i;
  assign m_axis.tlast  = tx_send & tx_last;
  assign m_axis.tkeep  = tx_send ? keep_mux : '0;
  assign tx_yumi_o     = tx_fire;

  assign s_axis.tready = rx_open & rx_ready_i;
  assign rx_v_o        = rx_open & s_axis.tvalid;
  assign rx_data_o     = rx_open ? s_axis.tdata : '0;

  assign tx_count_o = tx_count_reg;
  assign rx_count_o = rx_count_reg;
  assign status_o   = {1'b0, rx_open, tx_send, status_reg};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_reg  <= TX_IDLE;
      rx_state_reg  <= RX_IDLE;
      len_reg       <= '0;
      last_keep_reg <= '0;
      tx_count_reg  <= '0;
      rx_count_reg  <= '0;
      status_reg    <= '0;
    end else begin
      tx_state_reg  <= tx_state_next;
      rx_state_reg  <= rx_state_next;
      len_reg       <= len_next;
      last_keep_reg <= last_keep_next;
      tx_count_reg  <= tx_count_next;
      rx_count_reg  <= rx_count_next;
      status_reg    <= status_next;
    end
  end

  always_comb begin
    tx_state_next  = tx_state_reg;
    rx_state_next  = rx_state_reg;
    len_next       = len_reg;
    last_keep_next = last_keep_reg;
    tx_count_next  = tx_count_reg;
    rx_count_next  = rx_count_reg;
    status_next    = status_reg;

    if (start_i) begin
      // A restart wins over anything in flight. A bus handshake in this
      // cycle still happens, but it is deliberately not counted.
      len_next       = len_i;
      last_keep_next = last_keep_i;
      tx_count_next  = '0;
      rx_count_next  = '0;
      status_next    = '0;
      if (len_ok) begin
        tx_state_next = TX_SEND;
        rx_state_next = RX_RECV;
      end else begin
        status_next[st_cfg_err_lp] = 1'b1;
        tx_state_next = TX_IDLE;
        rx_state_next = RX_IDLE;
      end
    end else begin
      if (tx_fire) begin
        tx_count_next = tx_count_reg + one_lp;
        if (tx_last) begin
          status_next[st_tx_done_lp] = 1'b1;
          tx_state_next = TX_DONE;
        end
      end

      if (rx_fire) begin
        if (rx_count_reg != max_len_lp)
          rx_count_next = rx_count_reg + one_lp;
        case (rx_state_reg)
          RX_RECV: begin
            if (s_axis.tlast) begin
              // In RECV the count never exceeds len-1, so a miss means short.
              if (rx_len_hit) status_next[st_rx_ok_lp]    = 1'b1;
              else            status_next[st_rx_short_lp] = 1'b1;
              rx_state_next = RX_DONE;
            end else if (rx_len_hit) begin
              status_next[st_rx_long_lp] = 1'b1;
              rx_state_next = RX_DRAIN;
            end
          end
          RX_DRAIN: begin
            if (s_axis.tlast) rx_state_next = RX_DONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bsg_axis_txn_engine.sv
module tb_bsg_axis_txn_engine;
  localparam int DW   = 32;
  localparam int MAXL = 256;
  localparam int LW   = $clog2(MAXL + 1);
  localparam int KW   = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, start_i;
  logic [LW-1:0] len_i;
  logic [KW-1:0] last_keep_i;
  logic [DW-1:0] tx_data_i;
  logic          tx_v_i, tx_yumi_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_v_o, rx_ready_i;
  logic [LW-1:0] tx_count_o, rx_count_o;
  logic [7:0]    status_o;

  bsg_axis_txn_engine_if #(.data_width_p(DW)) m_axis_if ();
  bsg_axis_txn_engine_if #(.data_width_p(DW)) s_axis_if ();

  bsg_axis_txn_engine #(.data_width_p(DW), .max_len_p(MAXL)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .last_keep_i (last_keep_i),
    .tx_data_i   (tx_data_i),
    .tx_v_i      (tx_v_i),
    .tx_yumi_o   (tx_yumi_o),
    .m_axis      (m_axis_if.master),
    .s_axis      (s_axis_if.slave),
    .rx_data_o   (rx_data_o),
    .rx_v_o      (rx_v_o),
    .rx_ready_i  (rx_ready_i),
    .tx_count_o  (tx_count_o),
    .rx_count_o  (rx_count_o),
    .status_o    (status_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: transaction-level view of what the engine must do.
  logic [DW-1:0] tx_q[$];      // PS-to-PL FIFO contents, head first
  logic [DW-1:0] rx_words[$];  // current incoming frame
  int            cur_len, n_rx, tx_seen, rx_idx;
  logic [KW-1:0] cur_keep;
  bit            m_idle, m_cfg;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit coin(input int stall);
    return $urandom_range(0, 99) >= stall;
  endfunction

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s = '0;
    if (m_idle) return s;
    if (m_cfg) begin
      s[4] = 1'b1;
      return s;
    end
    s[0] = (tx_seen == cur_len);
    s[5] = (tx_seen < cur_len);
    s[6] = (rx_idx < n_rx);
    if (rx_idx == n_rx) begin
      if (n_rx == cur_len)     s[1] = 1'b1;
      else if (n_rx < cur_len) s[2] = 1'b1;
      else                     s[3] = 1'b1;
    end else if (rx_idx >= cur_len) begin
      s[3] = 1'b1;
    end
    return s;
  endfunction

  function automatic bit tx_active();
    return !m_idle && !m_cfg && (tx_seen < cur_len);
  endfunction

  function automatic bit rx_active();
    return !m_idle && !m_cfg && (rx_idx < n_rx);
  endfunction

  // One clock of random traffic with full checking of the bus against the model.
  task automatic step(input int stall);
    bit            tx_act, rx_act;
    logic [KW-1:0] exp_keep;
    bit            exp_last;
    @(negedge clk);
    reset_i = 1'b0;
    start_i = 1'b0;
    tx_act  = tx_active();
    rx_act  = rx_active();

    check_val("status", status_o, exp_status());
    check_val("tx_count", tx_count_o, tx_seen);
    check_val("rx_count", rx_count_o, (rx_idx > MAXL) ? MAXL : rx_idx);

    tx_v_i    = coin(stall) && (tx_q.size() > 0 || !tx_act);
    tx_data_i = (tx_q.size() > 0) ? tx_q[0] : DW'($urandom);
    m_axis_if.tready = coin(stall);
    s_axis_if.tvalid = coin(stall);
    s_axis_if.tkeep  = KW'($urandom);
    if (rx_idx < n_rx) begin
      s_axis_if.tdata = rx_words[rx_idx];
      s_axis_if.tlast = (rx_idx == n_rx - 1);
    end else begin
      s_axis_if.tdata = DW'($urandom);
      s_axis_if.tlast = 1'($urandom);
    end
    rx_ready_i = coin(stall);
    #1;

    check_val("m_tvalid", m_axis_if.tvalid, tx_act && tx_v_i);
    check_val("tx_yumi", tx_yumi_o, tx_act && tx_v_i && m_axis_if.tready);
    check_val("s_tready", s_axis_if.tready, rx_act && rx_ready_i);
    check_val("rx_v", rx_v_o, rx_act && s_axis_if.tvalid);
    if (!tx_act) check_val("m_tlast_idle", m_axis_if.tlast, 0);

    if (tx_act && tx_v_i && m_axis_if.tready) begin
      exp_last = (tx_seen == cur_len - 1);
      exp_keep = exp_last ? cur_keep : '1;
      check_val("m_tdata", m_axis_if.tdata, tx_q[0]);
      check_val("m_tlast", m_axis_if.tlast, exp_last);
      check_val("m_tkeep", m_axis_if.tkeep, exp_keep);
      void'(tx_q.pop_front());
      tx_seen++;
    end
    if (rx_act && s_axis_if.tvalid && rx_ready_i) begin
      check_val("rx_data", rx_data_o, rx_words[rx_idx]);
      rx_idx++;
    end
  endtask

  // Pulse start_i; optionally with a live handshake on both buses in that cycle.
  task automatic do_start(input int len, input logic [KW-1:0] keep, input int nrx, input bit hs);
    bit tx_act, rx_act;
    @(negedge clk);
    reset_i     = 1'b0;
    tx_act      = tx_active();
    rx_act      = rx_active();
    start_i     = 1'b1;
    len_i       = LW'(len);
    last_keep_i = keep;
    tx_v_i      = hs && (tx_q.size() > 0);
    tx_data_i   = (tx_q.size() > 0) ? tx_q[0] : '0;
    m_axis_if.tready = hs;
    s_axis_if.tvalid = hs && (rx_idx < n_rx);
    s_axis_if.tdata  = (rx_idx < n_rx) ? rx_words[rx_idx] : '0;
    s_axis_if.tlast  = 1'b0;
    rx_ready_i  = hs;
    #1;
    if (hs) begin
      check_val("start_hs_yumi", tx_yumi_o, tx_act && tx_v_i);
      check_val("start_hs_tready", s_axis_if.tready, rx_act);
      if (tx_act && tx_v_i) void'(tx_q.pop_front());
    end
    m_idle   = 1'b0;
    m_cfg    = (len == 0) || (len > MAXL);
    cur_len  = len;
    cur_keep = keep;
    n_rx     = m_cfg ? 0 : nrx;
    tx_seen  = 0;
    rx_idx   = 0;
    rx_words.delete();
    for (int i = 0; i < n_rx; i++) rx_words.push_back(DW'($urandom));
    if (!m_cfg) for (int i = 0; i < len; i++) tx_q.push_back(DW'($urandom));
    $display("[TB] start len=%0d keep=0x%0h rx_beats=%0d hs=%0d", len, keep, nrx, hs);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset_i = 1'b1;
      start_i = 1'b0;
      tx_v_i = 1'b0; m_axis_if.tready = 1'b0;
      s_axis_if.tvalid = 1'b0; rx_ready_i = 1'b0;
    end
    m_idle = 1'b1; m_cfg = 1'b0;
    cur_len = 0; n_rx = 0; tx_seen = 0; rx_idx = 0;
    rx_words.delete();
    $display("[TB] reset for %0d cycles", cycles);
  endtask

  task automatic run_done(input int stall, input int budget);
    int n;
    n = 0;
    while ((tx_active() || rx_active()) && n < budget) begin
      step(stall);
      n++;
    end
    if (tx_active() || rx_active()) check_val("timeout", 0, 1);
    for (int i = 0; i < 3; i++) step(stall);
    $display("[TB] done len=%0d tx=%0d rx=%0d status=0x%02h", cur_len, tx_seen, rx_idx, status_o);
  endtask

  task automatic run_tx_to(input int beats, input int budget);
    int n;
    n = 0;
    while (tx_seen < beats && n < budget) begin
      step(0);
      n++;
    end
    if (tx_seen < beats) check_val("timeout_tx", tx_seen, beats);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; len_i = '0; last_keep_i = '0;
    tx_data_i = '0; tx_v_i = 1'b0; rx_ready_i = 1'b0;
    m_axis_if.tready = 1'b0;
    s_axis_if.tdata = '0; s_axis_if.tvalid = 1'b0; s_axis_if.tkeep = '0; s_axis_if.tlast = 1'b0;
    do_reset(3);
    for (int i = 0; i < 3; i++) step(0);

    do_start(16, 4'hF, 16, 0); run_done(0, 500);   // nominal, ok
    do_start(8, 4'hF, 4, 0);   run_done(20, 500);  // short frame
    do_start(4, 4'hF, 7, 0);   run_done(20, 500);  // long frame, drained
    do_start(1, 4'h3, 1, 0);   run_done(0, 200);   // single beat carries keep
    do_start(32, 4'h7, 32, 0); run_done(40, 2000); // heavy stalls

    do_start(16, 4'hF, 16, 0); run_tx_to(5, 200);  // restart mid-frame
    do_start(16, 4'hF, 16, 1); run_done(0, 500);

    do_start(0, 4'hF, 4, 0);
    for (int i = 0; i < 4; i++) step(0);
    do_start(MAXL + 1, 4'hF, 4, 0);
    for (int i = 0; i < 4; i++) step(0);

    do_start(MAXL, 4'h1, MAXL, 0); run_done(30, 4000); // maximum length

    do_start(8, 4'hF, 8, 0);
    for (int i = 0; i < 3; i++) step(0);
    do_reset(1);                                     // reset mid-RECV
    for (int i = 0; i < 4; i++) step(0);

    for (int t = 0; t < 6; t++) begin
      do_start($urandom_range(1, 40), KW'($urandom), $urandom_range(1, 48), 0);
      run_done($urandom_range(0, 50), 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
